// File: rtl/veh_cmd_ctrl.sv
// Vehicle command controller: turns pkt_handler command words into throttle/steer PWM,
// with a link watchdog and a sticky kill state that force safe outputs.
module veh_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned PWM_DIV        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic        data_valid,
    input  logic        kill,
    input  logic        clr_kill,
    output logic        throttle_pwm,
    output logic        throttle_dir,
    output logic        steer_pwm,
    output logic        link_ok,
    output logic        estop,
    output logic [1:0]  state
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned PS_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned PWM_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ACTIVE  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_KILLED  = 2'b11;

    localparam logic [PWM_W-1:0] SAFE_THR   = 8'h00;
    localparam logic [PWM_W-1:0] SAFE_STEER = 8'h80;

    logic [1:0]       r_state;
    logic [WD_W-1:0]  r_wdog;
    logic [PWM_W-1:0] r_cmd_thr;
    logic [PWM_W-1:0] r_cmd_steer;
    logic             r_cmd_dir;
    logic             r_link_ok;
    logic             r_estop;
    logic             r_dir;

    logic [PS_W-1:0]  r_ps;
    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_thr_sh;
    logic [PWM_W-1:0] r_steer_sh;
    logic             r_thr_pwm;
    logic             r_steer_pwm;

    logic [1:0]       w_state_nxt;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic             w_capture;
    logic [PWM_W-1:0] w_thr_raw;
    logic [PWM_W-1:0] w_thr_mag;
    logic [PWM_W-1:0] w_cmd_thr_nxt;
    logic [PWM_W-1:0] w_cmd_steer_nxt;
    logic             w_cmd_dir_nxt;
    logic             w_active_nxt;
    logic [PWM_W-1:0] w_thr_eff;
    logic [PWM_W-1:0] w_steer_eff;
    logic             w_dir_eff;
    logic             w_leave_active;
    logic             w_ps_wrap;
    logic             w_cnt_wrap;

    // Next-state, watchdog and effective (safe-or-commanded) drive values
    always_comb begin
        w_state_nxt = r_state;
        w_wdog_nxt  = r_wdog;
        w_capture   = 1'b0;

        case (r_state)
            ST_IDLE, ST_TIMEOUT: begin
                if (kill) begin
                    w_state_nxt = ST_KILLED;
                end else if (data_valid) begin
                    w_state_nxt = ST_ACTIVE;
                    w_capture   = 1'b1;
                    w_wdog_nxt  = '0;
                end
            end
            ST_ACTIVE: begin
                if (kill) begin
                    w_state_nxt = ST_KILLED;
                end else if (data_valid) begin
                    w_capture  = 1'b1;
                    w_wdog_nxt = '0;
                end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_TIMEOUT;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            ST_KILLED: begin
                if (clr_kill && !kill) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // -128 has no positive counterpart in 8 bits, so it saturates to 127
        w_thr_raw = data[15:8];
        if (w_thr_raw[7]) begin
            w_thr_mag = (w_thr_raw == 8'h80) ? 8'h7F : PWM_W'(~w_thr_raw + 8'd1);
        end else begin
            w_thr_mag = w_thr_raw;
        end

        w_cmd_thr_nxt   = w_capture ? w_thr_mag : r_cmd_thr;
        w_cmd_steer_nxt = w_capture ? (data[7:0] ^ 8'h80) : r_cmd_steer;
        w_cmd_dir_nxt   = w_capture ? data[15] : r_cmd_dir;

        w_active_nxt   = (w_state_nxt == ST_ACTIVE);
        w_thr_eff      = w_active_nxt ? w_cmd_thr_nxt : SAFE_THR;
        w_steer_eff    = w_active_nxt ? w_cmd_steer_nxt : SAFE_STEER;
        w_dir_eff      = w_active_nxt & w_cmd_dir_nxt;
        w_leave_active = (r_state == ST_ACTIVE) && !w_active_nxt;
    end

    // State register, command capture and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wdog      <= '0;
            r_cmd_thr   <= SAFE_THR;
            r_cmd_steer <= SAFE_STEER;
            r_cmd_dir   <= 1'b0;
            r_link_ok   <= 1'b0;
            r_estop     <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wdog      <= w_wdog_nxt;
            r_cmd_thr   <= w_cmd_thr_nxt;
            r_cmd_steer <= w_cmd_steer_nxt;
            r_cmd_dir   <= w_cmd_dir_nxt;
            r_link_ok   <= w_active_nxt;
            r_estop     <= (w_state_nxt == ST_KILLED);
            r_dir       <= w_dir_eff;
        end
    end

    assign w_ps_wrap  = (r_ps == PS_W'(PWM_DIV - 1));
    assign w_cnt_wrap = w_ps_wrap && (r_cnt == 8'hFF);

    // PWM engine: shadows reload at the period boundary, except the throttle
    // shadow which is cut immediately when ACTIVE is left
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps        <= '0;
            r_cnt       <= '0;
            r_thr_sh    <= SAFE_THR;
            r_steer_sh  <= SAFE_STEER;
            r_thr_pwm   <= 1'b0;
            r_steer_pwm <= 1'b0;
        end else begin
            r_ps <= w_ps_wrap ? '0 : r_ps + PS_W'(1);
            if (w_ps_wrap) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_cnt_wrap) begin
                r_thr_sh   <= w_thr_eff;
                r_steer_sh <= w_steer_eff;
            end
            if (w_leave_active) begin
                r_thr_sh <= SAFE_THR;
            end
            r_thr_pwm   <= (r_cnt < r_thr_sh);
            r_steer_pwm <= (r_cnt < r_steer_sh);
        end
    end

    assign throttle_pwm = r_thr_pwm;
    assign throttle_dir = r_dir;
    assign steer_pwm    = r_steer_pwm;
    assign link_ok      = r_link_ok;
    assign estop        = r_estop;
    assign state        = r_state;

endmodule

// File: tb/tb_veh_cmd_ctrl.sv
// Bench for veh_cmd_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the link/kill rules and PWM duties.
module tb_veh_cmd_ctrl;

    localparam int unsigned TO  = 20;
    localparam int unsigned DIV = 1;

    localparam logic [1:0] M_IDLE    = 2'b00;
    localparam logic [1:0] M_ACTIVE  = 2'b01;
    localparam logic [1:0] M_TIMEOUT = 2'b10;
    localparam logic [1:0] M_KILLED  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        data_valid;
    logic        kill;
    logic        clr_kill;
    logic        throttle_pwm;
    logic        throttle_dir;
    logic        steer_pwm;
    logic        link_ok;
    logic        estop;
    logic [1:0]  state;

    always #5 clk = ~clk;

    veh_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .PWM_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .data_valid   (data_valid),
        .kill         (kill),
        .clr_kill     (clr_kill),
        .throttle_pwm (throttle_pwm),
        .throttle_dir (throttle_dir),
        .steer_pwm    (steer_pwm),
        .link_ok      (link_ok),
        .estop        (estop),
        .state        (state)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  m_st;
    int          m_since;
    logic [15:0] m_cmd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_thr(input logic [15:0] d);
        logic signed [7:0] t8;
        int t;
        t8 = d[15:8];
        t  = int'(t8);
        if (t == -128) return 127;
        return (t < 0) ? -t : t;
    endfunction

    function automatic int exp_steer(input logic [15:0] d);
        logic signed [7:0] s8;
        s8 = d[7:0];
        return int'(s8) + 128;
    endfunction

    task automatic model_reset();
        m_st    = M_IDLE;
        m_since = 0;
        m_cmd   = 16'h0000;
    endtask

    // One clock with the given inputs; model advances and status outputs are checked
    task automatic step(input logic dv, input logic [15:0] d, input logic k, input logic c);
        logic was_active;
        data_valid = dv;
        data       = d;
        kill       = k;
        clr_kill   = c;
        @(posedge clk);
        #1;
        was_active = (m_st == M_ACTIVE);
        if (k) begin
            m_st = M_KILLED;
        end else if (m_st == M_KILLED) begin
            if (c) m_st = M_IDLE;
        end else if (dv) begin
            m_st    = M_ACTIVE;
            m_cmd   = d;
            m_since = 0;
        end else if (m_st == M_ACTIVE) begin
            m_since++;
            if (m_since >= int'(TO)) m_st = M_TIMEOUT;
        end
        data_valid = 1'b0;
        kill       = 1'b0;
        clr_kill   = 1'b0;
        chk("state", 16'(state), 16'(m_st));
        chk("link_ok", 16'(link_ok), 16'(m_st == M_ACTIVE));
        chk("estop", 16'(estop), 16'(m_st == M_KILLED));
        chk("dir", 16'(throttle_dir), 16'((m_st == M_ACTIVE) && m_cmd[15]));
        if (!was_active) chk("thr_off", 16'(throttle_pwm), 16'h0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        kill       = 1'b0;
        clr_kill   = 1'b0;
        data       = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_state", 16'(state), 16'h0);
        chk("rst_link", 16'(link_ok), 16'h0);
        chk("rst_estop", 16'(estop), 16'h0);
        chk("rst_dir", 16'(throttle_dir), 16'h0);
        chk("rst_thr_pwm", 16'(throttle_pwm), 16'h0);
        chk("rst_steer_pwm", 16'(steer_pwm), 16'h0);
    endtask

    // Keep the link alive with word d and count high cycles over one steady period
    task automatic measure(input logic [15:0] d);
        int thr_hi;
        int st_hi;
        thr_hi = 0;
        st_hi  = 0;
        for (int i = 0; i < 520; i++) begin
            step((i % 10) == 0, d, 1'b0, 1'b0);
            if (i >= 264) begin
                thr_hi += int'(throttle_pwm);
                st_hi  += int'(steer_pwm);
            end
        end
        chk("thr_duty", 16'(thr_hi), 16'(exp_thr(d)));
        chk("steer_duty", 16'(st_hi), 16'(exp_steer(d)));
    endtask

    initial begin
        rst        = 1'b1;
        data       = 16'h0000;
        data_valid = 1'b0;
        kill       = 1'b0;
        clr_kill   = 1'b0;
        @(posedge clk);
        do_reset();

        // Scenario 1: first command
        step(1'b1, 16'h4000, 1'b0, 1'b0);
        chk("s1_state", 16'(state), 16'h1);
        measure(16'h4000);

        // Scenario 2: saturation and steering extremes
        measure(16'h807F);
        measure(16'h8180);

        // Scenario 3: timeout exactly TO cycles after the last accepted word
        step(1'b1, 16'h7F00, 1'b0, 1'b0);
        for (int i = 1; i < int'(TO); i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("s3_link_before", 16'(link_ok), 16'h1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("s3_link_fall", 16'(link_ok), 16'h0);
        chk("s3_state", 16'(state), 16'h2);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("s3_thr_low", 16'(throttle_pwm), 16'h0);
        step(1'b1, 16'h2000, 1'b0, 1'b0);
        chk("s3_reactivate", 16'(state), 16'h1);

        // Scenario 4: refresh every 19 cycles
        for (int i = 0; i < 200; i++) begin
            step((i % 19) == 0, 16'h3010, 1'b0, 1'b0);
            chk("s4_link", 16'(link_ok), 16'h1);
        end

        // Scenario 5: kill beats same-cycle data, then sticky behaviour
        step(1'b1, 16'h7F00, 1'b1, 1'b0);
        chk("s5_state", 16'(state), 16'h3);
        chk("s5_estop", 16'(estop), 16'h1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("s5_thr_low", 16'(throttle_pwm), 16'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(($urandom & 32'hFFFF) | 32'h8000), 1'b0, 1'b0);
        chk("s5_dv_ignored", 16'(state), 16'h3);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("s5_clr_kill_high", 16'(state), 16'h3);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("s5_cleared", 16'(state), 16'h0);
        chk("s5_estop_clr", 16'(estop), 16'h0);

        // Scenario 6: reset mid-period while ACTIVE with steer duty 200
        measure(16'h7F48);
        for (int i = 0; i < 37; i++) step(i == 5, 16'h7F48, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 16'h4000, 1'b0, 1'b0);
        chk("s6_state", 16'(state), 16'h1);
        measure(16'h4000);

        // Random traffic alternating dense and sparse command phases
        for (int i = 0; i < 1200; i++) begin
            logic dv;
            logic k;
            logic c;
            dv = ((i / 150) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
            k  = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 7) == 0);
            step(dv, 16'($urandom), k, c);
        end

        // Random command words: duty check
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) measure(16'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
